// File: rtl/shift_unit_arbiter.sv
// Two-requester arbiter in front of a shared 32-bit shift/rotate unit.
// One command in flight: IDLE accepts, EXEC computes, RESP returns to the issuing requester.
module shift_unit_arbiter #(
    parameter bit          RR_EN  = 1'b1,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [2:0]        req0_op_i,
    input  logic [DATA_W-1:0] req0_data_i,
    input  logic [4:0]        req0_shamt_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_data_o,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [2:0]        req1_op_i,
    input  logic [DATA_W-1:0] req1_data_i,
    input  logic [4:0]        req1_shamt_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_data_o,

    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [2:0] OpSll = 3'b000;
    localparam logic [2:0] OpSrl = 3'b001;
    localparam logic [2:0] OpSra = 3'b010;
    localparam logic [2:0] OpRol = 3'b011;
    localparam logic [2:0] OpRor = 3'b100;

    state_e state_q, state_d;

    logic [2:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [4:0]        shamt_q;
    logic              owner_q;
    logic              last_owner_q;
    logic [DATA_W-1:0] result_q;

    logic              grant;
    logic              accept0;
    logic              accept1;
    logic              cmd_hs;
    logic              rsp_hs;

    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] mask_rev;
    logic [5:0]        inv_shamt;
    logic [DATA_W-1:0] shift_res;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        grant = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = RR_EN ? ~last_owner_q : 1'b0;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
    end

    // Ready is gated by reset so no command slips in while the block is being cleared.
    assign accept0 = (state_q == StIdle) && !rst_i && req0_valid_i && !grant;
    assign accept1 = (state_q == StIdle) && !rst_i && req1_valid_i && grant;
    assign cmd_hs  = accept0 || accept1;
    assign rsp_hs  = (state_q == StResp) && (owner_q ? rsp1_ready_i : rsp0_ready_i);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_hs) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                if (rsp_hs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        busy_o       = 1'b0;
        unique case (state_q)
            StIdle: begin
                req0_ready_o = accept0;
                req1_ready_o = accept1;
            end
            StExec: begin
                busy_o = 1'b1;
            end
            StResp: begin
                busy_o       = 1'b1;
                rsp0_valid_o = !owner_q;
                rsp1_valid_o = owner_q;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    assign rsp0_data_o = rsp0_valid_o ? result_q : '0;
    assign rsp1_data_o = rsp1_valid_o ? result_q : '0;

    // ------------------------------------------------------------------
    // Command latch, result register, arbitration history
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q         <= 3'b000;
            data_q       <= '0;
            shamt_q      <= 5'd0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            result_q     <= '0;
        end else begin
            if (cmd_hs) begin
                owner_q <= accept1;
                if (accept1) begin
                    op_q    <= req1_op_i;
                    data_q  <= req1_data_i;
                    shamt_q <= req1_shamt_i;
                end else begin
                    op_q    <= req0_op_i;
                    data_q  <= req0_data_i;
                    shamt_q <= req0_shamt_i;
                end
            end
            if (state_q == StExec) begin
                result_q <= shift_res;
            end
            if (rsp_hs) begin
                last_owner_q <= owner_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shift datapath: thermometer mask (1<<s)-1 and its bit-reverse
    // ------------------------------------------------------------------
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            mask[i] = (i < int'(shamt_q));
        end
    end

    always_comb begin
        mask_rev = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            mask_rev[i] = mask[int'(DATA_W) - 1 - i];
        end
    end

    // 6-bit so that s=0 yields a 32-bit shift (all zeros), which the mask also suppresses.
    assign inv_shamt = 6'd32 - {1'b0, shamt_q};

    always_comb begin
        shift_res = data_q;
        case (op_q)
            OpSll: shift_res = data_q << shamt_q;
            OpSrl: shift_res = data_q >> shamt_q;
            OpSra: shift_res = (data_q >> shamt_q) | (data_q[DATA_W-1] ? mask_rev : '0);
            OpRol: shift_res = (data_q << shamt_q) | ((data_q >> inv_shamt) & mask);
            OpRor: shift_res = (data_q >> shamt_q) | ((data_q & mask) << inv_shamt);
            default: shift_res = data_q;
        endcase
    end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed self-checking bench for shift_unit_arbiter: round-robin and fixed-priority instances
// share all inputs; fixed-priority outputs are only inspected in the arbitration test.
module tb_shift_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0]  req0_op = 3'b0, req1_op = 3'b0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic [4:0]  req0_shamt = '0, req1_shamt = '0;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;

    logic        r0_rdy, r1_rdy, v0, v1, busy;
    logic [31:0] d0, d1;
    logic        f_r0_rdy, f_r1_rdy, f_v0, f_v1, f_busy;
    logic [31:0] f_d0, f_d1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.RR_EN(1'b1), .DATA_W(32)) dut_rr (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(req0_valid), .req0_ready_o(r0_rdy), .req0_op_i(req0_op),
        .req0_data_i(req0_data), .req0_shamt_i(req0_shamt),
        .rsp0_valid_o(v0), .rsp0_ready_i(rsp0_ready), .rsp0_data_o(d0),
        .req1_valid_i(req1_valid), .req1_ready_o(r1_rdy), .req1_op_i(req1_op),
        .req1_data_i(req1_data), .req1_shamt_i(req1_shamt),
        .rsp1_valid_o(v1), .rsp1_ready_i(rsp1_ready), .rsp1_data_o(d1),
        .busy_o(busy)
    );

    shift_unit_arbiter #(.RR_EN(1'b0), .DATA_W(32)) dut_fp (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(req0_valid), .req0_ready_o(f_r0_rdy), .req0_op_i(req0_op),
        .req0_data_i(req0_data), .req0_shamt_i(req0_shamt),
        .rsp0_valid_o(f_v0), .rsp0_ready_i(rsp0_ready), .rsp0_data_o(f_d0),
        .req1_valid_i(req1_valid), .req1_ready_o(f_r1_rdy), .req1_op_i(req1_op),
        .req1_data_i(req1_data), .req1_shamt_i(req1_shamt),
        .rsp1_valid_o(f_v1), .rsp1_ready_i(rsp1_ready), .rsp1_data_o(f_d1),
        .busy_o(f_busy)
    );

    // Reference model built on a doubled word instead of masks.
    function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] d,
                                              input logic [4:0] s);
        logic [63:0] dd;
        dd = {d, d};
        case (op)
            3'b000: return d << s;
            3'b001: return d >> s;
            3'b010: return $unsigned($signed(d) >>> s);
            3'b011: begin dd = dd << s; return dd[63:32]; end
            3'b100: begin dd = dd >> s; return dd[31:0]; end
            default: return d;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    // Drives one requester-0 command and takes its response; got is X if it never arrives.
    task automatic run_op0(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s,
                           output logic [31:0] got);
        int n;
        req0_valid = 1'b1; req0_op = op; req0_data = d; req0_shamt = s;
        #1;
        n = 0;
        while (!r0_rdy && n < 8) begin cyc(); #1; n++; end
        cyc();
        req0_valid = 1'b0;
        #1;
        n = 0;
        while (!v0 && n < 8) begin cyc(); #1; n++; end
        got = v0 ? d0 : 32'hxxxx_xxxx;
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        rst_i = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if ({r0_rdy, r1_rdy, v0, v1, busy} !== 5'b0 || d0 !== 32'h0 || d1 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs got rdy=%b%b v=%b%b busy=%b d0=%h d1=%h want all 0",
                     r0_rdy, r1_rdy, v0, v1, busy, d0, d1);
        end
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if (busy !== 1'b0 || v0 !== 1'b0 || v1 !== 1'b0) begin
                n_err++;
                $display("FAIL idle_after_reset[%0d] got busy=%b v0=%b v1=%b want 0", i, busy, v0, v1);
            end
        end
    endtask

    task automatic test_sra_latency();
        do_reset();
        req0_valid = 1'b1; req0_op = 3'b010; req0_data = 32'h8000_0010; req0_shamt = 5'd4;
        #1;
        n_cmp++;
        if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL sra_ready_T got r0=%b r1=%b want 1 0", r0_rdy, r1_rdy);
        end
        cyc();
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if (v0 !== 1'b0 || busy !== 1'b1 || r0_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL sra_T1 got v0=%b busy=%b r0=%b want 0 1 0", v0, busy, r0_rdy);
        end
        cyc();
        n_cmp++;
        if (v0 !== 1'b1 || d0 !== 32'hF800_0001) begin
            n_err++;
            $display("FAIL sra_T2 got v0=%b d0=%h want 1 f8000001", v0, d0);
        end
        n_cmp++;
        if (v1 !== 1'b0 || d1 !== 32'h0) begin
            n_err++;
            $display("FAIL sra_rsp1_quiet got v1=%b d1=%h want 0 0", v1, d1);
        end
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || v0 !== 1'b0 || d0 !== 32'h0) begin
            n_err++;
            $display("FAIL sra_done got busy=%b v0=%b d0=%h want 0 0 0", busy, v0, d0);
        end
    endtask

    // Both requesters stay valid; expected owner sequence is 0,1,0,1 (rr) or 0,0,0,0 (fp).
    task automatic test_arbitration(input bit use_fp);
        int n;
        logic g_rdy0, g_rdy1, g_v0, g_v1;
        logic [31:0] g_d0, g_d1;
        logic exp_g;
        do_reset();
        req0_op = 3'b101; req0_data = 32'h1111_1111; req0_shamt = 5'd3;
        req1_op = 3'b101; req1_data = 32'h2222_2222; req1_shamt = 5'd3;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_g = use_fp ? 1'b0 : k[0];
            n = 0;
            g_rdy0 = use_fp ? f_r0_rdy : r0_rdy;
            g_rdy1 = use_fp ? f_r1_rdy : r1_rdy;
            while (!(g_rdy0 || g_rdy1) && n < 8) begin
                cyc(); #1; n++;
                g_rdy0 = use_fp ? f_r0_rdy : r0_rdy;
                g_rdy1 = use_fp ? f_r1_rdy : r1_rdy;
            end
            n_cmp++;
            if ({g_rdy1, g_rdy0} !== (exp_g ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL grant fp=%0d k=%0d got rdy1,rdy0=%b%b want owner %0d",
                         use_fp, k, g_rdy1, g_rdy0, exp_g);
            end
            cyc(); #1;
            n = 0;
            g_v0 = use_fp ? f_v0 : v0;
            g_v1 = use_fp ? f_v1 : v1;
            while (!(g_v0 || g_v1) && n < 8) begin
                cyc(); #1; n++;
                g_v0 = use_fp ? f_v0 : v0;
                g_v1 = use_fp ? f_v1 : v1;
            end
            g_d0 = use_fp ? f_d0 : d0;
            g_d1 = use_fp ? f_d1 : d1;
            n_cmp++;
            if (exp_g ? (g_v1 !== 1'b1 || g_v0 !== 1'b0 || g_d1 !== 32'h2222_2222)
                      : (g_v0 !== 1'b1 || g_v1 !== 1'b0 || g_d0 !== 32'h1111_1111)) begin
                n_err++;
                $display("FAIL route fp=%0d k=%0d got v=%b%b d0=%h d1=%h want owner %0d",
                         use_fp, k, g_v1, g_v0, g_d0, g_d1, exp_g);
            end
            cyc(); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_ror_hold();
        do_reset();
        req1_valid = 1'b1; req1_op = 3'b100; req1_data = 32'h0000_00F1; req1_shamt = 5'd4;
        #1;
        n_cmp++;
        if (r1_rdy !== 1'b1 || r0_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL ror_accept got r1=%b r0=%b want 1 0", r1_rdy, r0_rdy);
        end
        cyc();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b000; req0_data = 32'h1234_5678; req0_shamt = 5'd1;
        #1;
        n_cmp++;
        if (r0_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL ror_exec_ready0 got %b want 0", r0_rdy);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            n_cmp++;
            if (v1 !== 1'b1 || d1 !== 32'h1000_000F || r0_rdy !== 1'b0 || v0 !== 1'b0) begin
                n_err++;
                $display("FAIL ror_hold[%0d] got v1=%b d1=%h r0=%b v0=%b want 1 1000000f 0 0",
                         i, v1, d1, r0_rdy, v0);
            end
        end
        rsp1_ready = 1'b1;
        cyc();
        rsp1_ready = 1'b0;
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if (v1 !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ror_release got v1=%b busy=%b want 0 0", v1, busy);
        end
        cyc();
    endtask

    task automatic test_sweep();
        logic [31:0] got, exp;
        logic [2:0] ops [3];
        logic [31:0] d;
        ops[0] = 3'b011; ops[1] = 3'b000; ops[2] = 3'b001;
        d = 32'hA5C3_0F81;
        do_reset();
        for (int o = 0; o < 3; o++) begin
            for (int s = 0; s < 32; s++) begin
                run_op0(ops[o], d, 5'(s), got);
                exp = ref_shift(ops[o], d, 5'(s));
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL sweep op=%b s=%0d got %h want %h", ops[o], s, got, exp);
                end
                if (s == 0) begin
                    n_cmp++;
                    if (got !== 32'hA5C3_0F81) begin
                        n_err++;
                        $display("FAIL s0_identity op=%b got %h want a5c30f81", ops[o], got);
                    end
                end
            end
        end
        run_op0(3'b111, d, 5'd7, got);
        n_cmp++;
        if (got !== 32'hA5C3_0F81) begin
            n_err++;
            $display("FAIL op111_pass got %h want a5c30f81", got);
        end
        run_op0(3'b011, 32'h8000_0001, 5'd1, got);
        n_cmp++;
        if (got !== 32'h0000_0003) begin
            n_err++;
            $display("FAIL rol_wrap got %h want 00000003", got);
        end
    endtask

    task automatic test_reset_abort(input bit in_resp);
        logic [31:0] got;
        do_reset();
        run_op0(3'b101, 32'hCAFE_0000, 5'd0, got);  // leaves last owner = 0
        req1_valid = 1'b1; req1_op = 3'b000; req1_data = 32'h0000_0001; req1_shamt = 5'd2;
        #1;
        n_cmp++;
        if (r1_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_setup_accept resp=%0d got r1=%b want 1", in_resp, r1_rdy);
        end
        cyc();
        req1_valid = 1'b0;
        if (in_resp) begin
            cyc();
            n_cmp++;
            if (v1 !== 1'b1 || d1 !== 32'h0000_0004) begin
                n_err++;
                $display("FAIL abort_setup_resp got v1=%b d1=%h want 1 00000004", v1, d1);
            end
        end
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (busy !== 1'b0 || v0 !== 1'b0 || v1 !== 1'b0 || d1 !== 32'h0) begin
                n_err++;
                $display("FAIL abort_idle resp=%0d c=%0d got busy=%b v=%b%b d1=%h want 0",
                         in_resp, i, busy, v1, v0, d1);
            end
            cyc(); #1;
        end
        req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 3'b101; req1_op = 3'b101;
        #1;
        n_cmp++;
        if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_first_contest resp=%0d got r0=%b r1=%b want 1 0",
                     in_resp, r0_rdy, r1_rdy);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_sra_latency();
        test_arbitration(1'b0);
        test_arbitration(1'b1);
        test_ror_hold();
        test_sweep();
        test_reset_abort(1'b0);
        test_reset_abort(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
